// File: rtl/sar_sample_averager.sv
// SAR ADC sequencer: paced start pulses, windowed rounded mean, sticky timeout.
// Optional window min/max tracking is enabled by defining SAR_AVG_MINMAX_EN.
module sar_sample_averager #(
  parameter int WIDTH          = 8,
  parameter int LOG2_SAMPLES   = 4,
  parameter int GAP_CYCLES     = 16,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             clear_err,
  input  logic [WIDTH-1:0] adc_result,
  input  logic             conversion_done,
  output logic             start,
  output logic [WIDTH-1:0] avg_out,
  output logic             avg_valid,
  output logic             timeout_err,
  output logic [WIDTH-1:0] min_out,
  output logic [WIDTH-1:0] max_out
);

  localparam int AW = WIDTH + LOG2_SAMPLES;
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  localparam logic [TW-1:0] TMO_LAST =
    TW'(TIMEOUT_CYCLES - 1);
  localparam logic [GW-1:0] GAP_LAST =
    GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [LOG2_SAMPLES-1:0] CNT_LAST = '1;
  localparam logic [AW-1:0] HALF =
    AW'(1) << (LOG2_SAMPLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    TRIGGER,
    WAIT_DONE,
    ACCUM,
    GAP
  } state_t;

  state_t state;
  state_t state_next;
  state_t after_sample;

  logic [TW-1:0]           tmo_cnt;
  logic [TW-1:0]           tmo_next;
  logic [GW-1:0]           gap_cnt;
  logic [AW-1:0]           acc;
  logic [AW-1:0]           acc_new;
  logic [AW-1:0]           acc_rnd;
  logic [LOG2_SAMPLES-1:0] cnt;
  logic [WIDTH-1:0]        sample;
  logic                    tmo_hit;
  logic                    last;
  logic                    gap_done;

  assign start    = (state == TRIGGER);
  assign tmo_next = tmo_cnt + TW'(1);
  assign tmo_hit  = (state == WAIT_DONE)
                 && !conversion_done
                 && (tmo_next == TMO_LAST);
  assign acc_new  = acc + AW'(sample);
  assign acc_rnd  = acc_new + HALF;
  assign last     = (cnt == CNT_LAST);
  assign gap_done = (gap_cnt == GAP_LAST);

  // With no gap the sequencer re-triggers straight out of ACCUM.
  always_comb begin
    after_sample = GAP;
    if (GAP_CYCLES == 0) begin
      after_sample = enable ? TRIGGER : IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (enable) state_next = TRIGGER;
      end
      TRIGGER: begin
        state_next = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (conversion_done) begin
          state_next = ACCUM;
        end else if (tmo_hit) begin
          state_next = after_sample;
        end
      end
      ACCUM: begin
        state_next = after_sample;
      end
      GAP: begin
        if (gap_done) begin
          state_next = enable ? TRIGGER : IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tmo_cnt     <= '0;
      gap_cnt     <= '0;
      acc         <= '0;
      cnt         <= '0;
      sample      <= '0;
      avg_out     <= '0;
      avg_valid   <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      avg_valid <= 1'b0;
      if (tmo_hit) begin
        timeout_err <= 1'b1;
      end else if (clear_err) begin
        timeout_err <= 1'b0;
      end
      unique case (state)
        IDLE: begin
          acc <= '0;
          cnt <= '0;
        end
        TRIGGER: begin
          tmo_cnt <= '0;
        end
        WAIT_DONE: begin
          tmo_cnt <= tmo_next;
          gap_cnt <= '0;
          if (conversion_done) begin
            sample <= adc_result;
          end else if (tmo_hit) begin
            acc <= '0;
            cnt <= '0;
          end
        end
        ACCUM: begin
          gap_cnt <= '0;
          if (last) begin
            acc       <= '0;
            cnt       <= '0;
            avg_out   <= WIDTH'(acc_rnd >> LOG2_SAMPLES);
            avg_valid <= 1'b1;
          end else begin
            acc <= acc_new;
            cnt <= cnt + LOG2_SAMPLES'(1);
          end
        end
        GAP: begin
          gap_cnt <= gap_cnt + GW'(1);
        end
        default: ;
      endcase
    end
  end

`ifdef SAR_AVG_MINMAX_EN
  logic [WIDTH-1:0] run_min;
  logic [WIDTH-1:0] run_max;
  logic [WIDTH-1:0] min_new;
  logic [WIDTH-1:0] max_new;

  assign min_new = (sample < run_min) ? sample : run_min;
  assign max_new = (sample > run_max) ? sample : run_max;

  // Outputs only move on a completed window; discarded ones leave them.
  always_ff @(posedge clk) begin
    if (reset) begin
      run_min <= '1;
      run_max <= '0;
      min_out <= '0;
      max_out <= '0;
    end else if (state == IDLE || tmo_hit) begin
      run_min <= '1;
      run_max <= '0;
    end else if (state == ACCUM) begin
      if (last) begin
        min_out <= min_new;
        max_out <= max_new;
        run_min <= '1;
        run_max <= '0;
      end else begin
        run_min <= min_new;
        run_max <= max_new;
      end
    end
  end
`else
  assign min_out = '0;
  assign max_out = '0;
`endif

endmodule

// File: tb/tb_sar_sample_averager.sv
// Directed bench for sar_sample_averager (N=4, gap 3, timeout 20).
// Converter is modelled by tasks answering each start after a set delay.
module tb_sar_sample_averager;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         enable = 1'b0;
  logic         clear_err = 1'b0;
  logic [W-1:0] adc_result = '0;
  logic         conversion_done = 1'b0;
  logic         start;
  logic [W-1:0] avg_out;
  logic         avg_valid;
  logic         timeout_err;
  logic [W-1:0] min_out;
  logic [W-1:0] max_out;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int vpulses = 0;
  int spulses = 0;
  logic start_q = 1'b0;

  always #5 clk = ~clk;

  sar_sample_averager #(
    .WIDTH(8),
    .LOG2_SAMPLES(2),
    .GAP_CYCLES(3),
    .TIMEOUT_CYCLES(20)
  ) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .clear_err(clear_err),
    .adc_result(adc_result),
    .conversion_done(conversion_done),
    .start(start),
    .avg_out(avg_out),
    .avg_valid(avg_valid),
    .timeout_err(timeout_err),
    .min_out(min_out),
    .max_out(max_out)
  );

  always @(posedge clk) begin
    cyc++;
    if (avg_valid === 1'b1) vpulses++;
    if (start === 1'b1) spulses++;
    if (start === 1'b1 && start_q === 1'b1) begin
      errors++;
      $display("FAIL start_back_to_back: start high 2 cycles at cycle %0d", cyc);
    end
    start_q <= start;
  end

  typedef struct packed {
    logic [3:0][7:0] s;
    logic [7:0]      avg;
  } vec_t;

  vec_t vecs [9];

  function automatic vec_t mk(input logic [7:0] a, input logic [7:0] b,
                              input logic [7:0] c, input logic [7:0] d,
                              input logic [7:0] e);
    vec_t v;
    v.s[0] = a;
    v.s[1] = b;
    v.s[2] = c;
    v.s[3] = d;
    v.avg  = e;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic wait_start(output int at);
    int n;
    n = 0;
    while (start !== 1'b1 && n < 60) begin
      step();
      n++;
    end
    if (start !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL start_wait: got no start, expected one within 60 cycles");
    end
    at = cyc;
  endtask

  // Answers the next start with done held high `dly` cycles later.
  task automatic convert(input logic [7:0] v, input int dly, output int at);
    wait_start(at);
    repeat (dly) step();
    adc_result      = v;
    conversion_done = 1'b1;
    step();
    conversion_done = 1'b0;
    adc_result      = ~v;
  endtask

  // Four conversions; expects the strobe exactly 2 cycles after the last done.
  task automatic run_window(input string name, input vec_t v, input int dly);
    int at;
    int first;
    first = 0;
    for (int i = 0; i < 4; i++) begin
      convert(v.s[i], dly + i, at);
      if (i == 0) first = at;
      // start-to-start: dly to done, +1 ACCUM, +3 GAP, +1 to TRIGGER
      if (i == 1) check({name, "_start_spacing"}, at - first, dly + 5);
    end
    check({name, "_valid_early"}, avg_valid, 0);
    step();
    check({name, "_valid"}, avg_valid, 1);
    check({name, "_avg"}, avg_out, v.avg);
    step();
    check({name, "_valid_single"}, avg_valid, 0);
  endtask

  initial begin
    int at;
    int p;
    int vp;
    int sp;

    vecs[0] = mk(8'd10,  8'd11,  8'd12,  8'd13,  8'd12);
    vecs[1] = mk(8'd255, 8'd255, 8'd255, 8'd255, 8'd255);
    vecs[2] = mk(8'd0,   8'd0,   8'd0,   8'd1,   8'd0);
    vecs[3] = mk(8'd1,   8'd1,   8'd1,   8'd0,   8'd1);
    vecs[4] = mk(8'd0,   8'd1,   8'd1,   8'd0,   8'd1);
    vecs[5] = mk(8'd0,   8'd0,   8'd1,   8'd0,   8'd0);
    vecs[6] = mk(8'd3,   8'd4,   8'd4,   8'd4,   8'd4);
    vecs[7] = mk(8'd254, 8'd255, 8'd255, 8'd255, 8'd255);
    vecs[8] = mk(8'd128, 8'd0,   8'd255, 8'd1,   8'd96);

    step();
    step();
    check("rst_start", start, 0);
    check("rst_avg", avg_out, 0);
    check("rst_valid", avg_valid, 0);
    check("rst_err", timeout_err, 0);
    check("rst_min", min_out, 0);
    check("rst_max", max_out, 0);
    reset  = 1'b0;
    enable = 1'b1;

    for (int k = 0; k < 9; k++) begin
      run_window($sformatf("vec%0d", k), vecs[k], 1 + (k % 3));
    end

    // Enable drops after two samples of a window: partial window dropped.
    convert(8'd0, 2, at);
    convert(8'd0, 2, at);
    enable = 1'b0;
    vp = vpulses;
    sp = spulses;
    repeat (12) step();
    check("partial_no_valid", vpulses, vp);
    check("idle_no_start", spulses, sp);
    enable = 1'b1;
    run_window("reenable", mk(8'd100, 8'd100, 8'd100, 8'd100, 8'd100), 2);

    // Timeout mid-window: partial window discarded, late done ignored.
    convert(8'd200, 1, at);
    convert(8'd200, 1, at);
    wait_start(p);
    repeat (19) step();
    check("tmo_not_yet", timeout_err, 0);
    step();
    check("tmo_set", timeout_err, 1);
    adc_result      = 8'd99;
    conversion_done = 1'b1;
    step();
    conversion_done = 1'b0;
    wait_start(at);
    check("tmo_restart_delay", at - p, 23);
    run_window("after_tmo", mk(8'd40, 8'd41, 8'd42, 8'd43, 8'd42), 1);
    check("tmo_sticky", timeout_err, 1);

    // Reset while waiting for a conversion.
    wait_start(at);
    step();
    reset = 1'b1;
    step();
    check("mid_rst_start", start, 0);
    check("mid_rst_avg", avg_out, 0);
    check("mid_rst_err", timeout_err, 0);
    check("mid_rst_valid", avg_valid, 0);
    reset = 1'b0;
    step();
    check("mid_rst_retrigger", start, 1);
    run_window("after_rst", vecs[0], 3);

    // Second timeout, then clear_err.
    wait_start(p);
    repeat (20) step();
    check("tmo2_set", timeout_err, 1);
    check("tmo2_avg_kept", avg_out, 12);
    clear_err = 1'b1;
    step();
    clear_err = 1'b0;
    check("clear_err", timeout_err, 0);

    enable = 1'b0;
    repeat (10) step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
